// File: rtl/msg_arb_pkg.sv
// msg_arb_pkg: shared FSM encoding and message geometry for the CPU message FIFO arbiter.
package msg_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, W0 = 2'd2, W1 = 2'd3} state_t;
  localparam int MSG_WORDS = 3;
  localparam int SEQ_W = 8;
endpackage

// File: rtl/msg_fifo_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request above the last grant.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] w_c;
  // Scan farthest-first so the nearest requester above i_last is the last write.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_c   = '0;
    for (int k = N; k >= 1; k--) begin
      w_c = IW'((int'(i_last) + k) % N);
      if (i_req[w_c]) begin
        o_idx      = w_c;
        o_gnt      = '0;
        o_gnt[w_c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/msg_fifo_arbiter.sv
// msg_fifo_arbiter: round-robin writer of atomic 3-word messages into the CPU message FIFO.
// Define MSG_ARB_SEQ_EN to replace tag[7:0] with a per-message sequence number.
module msg_fifo_arbiter #(
  parameter int NUM_SRC    = 5,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_SRC-1:0]    src_req,
  input  logic [NUM_SRC*32-1:0] src_tag,
  input  logic [NUM_SRC*32-1:0] src_word0,
  input  logic [NUM_SRC*32-1:0] src_word1,
  output logic [NUM_SRC-1:0]    src_ack,
  input  logic [USEDW_W-1:0]    fifo_usedw,
  input  logic                  fifo_flush,
  output logic                  fifo_wrreq,
  output logic [31:0]           fifo_data,
  output logic                  busy
);
  import msg_arb_pkg::*;
  localparam int IW = $clog2(NUM_SRC);
  localparam logic [USEDW_W:0] SPACE_LIM = (USEDW_W+1)'(FIFO_DEPTH - MSG_WORDS);
  state_t               r_state;
  logic [IW-1:0]        r_last, r_win;
  logic [NUM_SRC-1:0]   r_win_oh, r_ack;
  logic [31:0]          r_w0, r_w1, r_data;
  logic                 r_wrreq, r_busy;
  logic                 w_space_ok;
  logic [NUM_SRC-1:0]   w_gnt;
  logic [IW-1:0]        w_idx;
  logic [31:0]          w_tag, w_hdr;
  assign w_space_ok = ({1'b0, fifo_usedw} < SPACE_LIM) && !fifo_flush;
  assign w_tag      = src_tag[w_idx*32 +: 32];
  rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
    .i_req  (src_req),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );
`ifdef MSG_ARB_SEQ_EN
  logic [SEQ_W-1:0] r_seq;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_seq <= '0;
    else if (r_state == W1) r_seq <= r_seq + 1'b1;
  assign w_hdr = {w_tag[31:SEQ_W], r_seq};
`else
  assign w_hdr = w_tag;
`endif
  // The header goes straight into r_data at grant; word0/word1 are held until their slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_wrreq  <= 1'b0;
      r_data   <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_last   <= IW'(NUM_SRC - 1);
      r_win    <= '0;
      r_win_oh <= '0;
      r_w0     <= '0;
      r_w1     <= '0;
    end else begin
      case (r_state)
        IDLE: if (|src_req && w_space_ok) begin
          r_state  <= HDR;
          r_wrreq  <= 1'b1;
          r_busy   <= 1'b1;
          r_data   <= w_hdr;
          r_w0     <= src_word0[w_idx*32 +: 32];
          r_w1     <= src_word1[w_idx*32 +: 32];
          r_win    <= w_idx;
          r_win_oh <= w_gnt;
        end
        HDR: if (fifo_flush) begin
          r_state <= IDLE;
          r_wrreq <= 1'b0;
          r_data  <= '0;
          r_busy  <= 1'b0;
        end else begin
          r_state <= W0;
          r_data  <= r_w0;
        end
        W0: if (fifo_flush) begin
          r_state <= IDLE;
          r_wrreq <= 1'b0;
          r_data  <= '0;
          r_busy  <= 1'b0;
        end else begin
          r_state <= W1;
          r_data  <= r_w1;
          r_ack   <= r_win_oh;
        end
        W1: begin
          r_state <= IDLE;
          r_wrreq <= 1'b0;
          r_data  <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_win;
        end
      endcase
    end
  end
  assign fifo_wrreq = r_wrreq;
  assign fifo_data  = r_data;
  assign src_ack    = r_ack;
  assign busy       = r_busy;
endmodule

// File: tb/tb_msg_fifo_arbiter.sv
// tb_msg_fifo_arbiter: directed checks of grant order, atomic writes, backpressure, flush and reset.
module tb_msg_fifo_arbiter;
  localparam int NS = 5;
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NS-1:0]    src_req = '0;
  logic [NS*32-1:0] src_tag = '0, src_word0 = '0, src_word1 = '0;
  logic [NS-1:0]    src_ack;
  logic [7:0]       fifo_usedw = '0;
  logic             fifo_flush = 1'b0;
  logic             fifo_wrreq;
  logic [31:0]      fifo_data;
  logic             busy;
  logic [31:0]      exp_tag [NS];
  logic [31:0]      exp_w0  [NS];
  logic [31:0]      exp_w1  [NS];
  logic [7:0]       exp_seq = '0;
  int vectors = 0, miscompares = 0, cyc = 0;
  int h0, h1;

  msg_fifo_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(256), .USEDW_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_tag(src_tag),
    .src_word0(src_word0), .src_word1(src_word1), .src_ack(src_ack),
    .fifo_usedw(fifo_usedw), .fifo_flush(fifo_flush), .fifo_wrreq(fifo_wrreq),
    .fifo_data(fifo_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_hdr(input int s);
`ifdef MSG_ARB_SEQ_EN
    return {exp_tag[s][31:8], exp_seq};
`else
    return exp_tag[s];
`endif
  endfunction

  task automatic load();
    for (int i = 0; i < NS; i++) begin
      src_tag[32*i +: 32]   = exp_tag[i];
      src_word0[32*i +: 32] = exp_w0[i];
      src_word1[32*i +: 32] = exp_w1[i];
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    src_req = '0;
    fifo_flush = 1'b0;
    fifo_usedw = '0;
    step();
    step();
    chk("rst_wrreq", 32'(fifo_wrreq), 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_ack", 32'(src_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    exp_seq = '0;
  endtask

  // Waits up to wmax extra cycles for a header, then checks the whole message.
  task automatic do_msg(input int src, input int wmax, input bit abort_w0,
                        input bit flush_w1, input bit poke_w1, output int hcyc);
    int n = 0;
    step();
    while (!fifo_wrreq && n < wmax) begin
      step();
      n++;
    end
    hcyc = cyc;
    chk("hdr_wrreq", 32'(fifo_wrreq), 1);
    chk("hdr_data", fifo_data, exp_hdr(src));
    chk("hdr_busy", 32'(busy), 1);
    chk("hdr_ack", 32'(src_ack), 0);
    if (poke_w1) src_word1[32*src +: 32] = 32'hDEAD_BEEF;
    step();
    chk("w0_wrreq", 32'(fifo_wrreq), 1);
    chk("w0_data", fifo_data, exp_w0[src]);
    if (abort_w0) begin
      fifo_flush = 1'b1;
      step();
      fifo_flush = 1'b0;
      chk("abort_wrreq", 32'(fifo_wrreq), 0);
      chk("abort_ack", 32'(src_ack), 0);
      chk("abort_busy", 32'(busy), 0);
      return;
    end
    step();
    chk("w1_wrreq", 32'(fifo_wrreq), 1);
    chk("w1_data", fifo_data, exp_w1[src]);
    chk("w1_ack", 32'(src_ack), 32'(1) << src);
    src_req[src] = 1'b0;
    if (flush_w1) fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
    chk("idle_wrreq", 32'(fifo_wrreq), 0);
    chk("idle_data", fifo_data, 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ack", 32'(src_ack), 0);
    exp_seq++;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      exp_tag[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0011;
      exp_w0[i]  = 32'hB000_0000 + 32'(i);
      exp_w1[i]  = 32'hC000_0000 + 32'(i);
    end
    exp_tag[0] = 32'h0052_4242;
    exp_w0[0]  = 32'h1234_0056;
    exp_w1[0]  = 32'h0000_0101;
    load();
    // single message from source 0
    do_reset();
    src_req = 5'b00001;
    do_msg(0, 0, 0, 0, 0, h0);
    step();
    chk("stay_idle", 32'(fifo_wrreq), 0);
    // round-robin order 0,2,4,0,2 at one header per 4 cycles
    do_reset();
    src_req = 5'b10101;
    do_msg(0, 0, 0, 0, 0, h0);
    src_req[0] = 1'b1;
    do_msg(2, 0, 0, 0, 0, h1);
    chk("gap_0_2", 32'(h1 - h0), 4);
    src_req[2] = 1'b1;
    do_msg(4, 0, 0, 0, 0, h0);
    chk("gap_2_4", 32'(h0 - h1), 4);
    src_req[4] = 1'b1;
    do_msg(0, 0, 0, 0, 0, h1);
    chk("gap_4_0", 32'(h1 - h0), 4);
    src_req[0] = 1'b1;
    do_msg(2, 0, 0, 0, 0, h0);
    chk("gap_0_2b", 32'(h0 - h1), 4);
    // backpressure at the space threshold, and flush while idle
    do_reset();
    fifo_usedw = 8'd253;
    src_req = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_wrreq", 32'(fifo_wrreq), 0);
      chk("full_busy", 32'(busy), 0);
    end
    fifo_usedw = 8'd252;
    do_msg(1, 0, 0, 0, 0, h0);
    fifo_usedw = 8'd0;
    fifo_flush = 1'b1;
    src_req = 5'b00001;
    step();
    chk("flush_idle_wrreq", 32'(fifo_wrreq), 0);
    fifo_flush = 1'b0;
    do_msg(0, 0, 0, 0, 0, h0);
    // flush in W0 aborts source 3, which then re-wins over source 0
    do_reset();
    src_req = 5'b00100;
    do_msg(2, 0, 0, 0, 0, h0);
    src_req = 5'b01001;
    do_msg(3, 0, 1, 0, 0, h0);
    do_msg(3, 0, 0, 0, 0, h0);
    // flush in W1 still completes and advances the round-robin pointer
    do_msg(0, 0, 0, 1, 0, h0);
    src_req = 5'b00011;
    do_msg(1, 0, 0, 0, 0, h0);
    src_req = 5'b00000;
    // word1 altered after grant must not reach the FIFO
    src_req = 5'b10000;
    do_msg(4, 0, 0, 0, 1, h0);
    load();
    // async reset mid-message clears outputs without a clock edge
    src_req = 5'b00001;
    step();
    chk("pre_rst_wrreq", 32'(fifo_wrreq), 1);
    step();
    reset_n = 1'b0;
    #1;
    chk("async_wrreq", 32'(fifo_wrreq), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_data", fifo_data, 0);
    chk("async_ack", 32'(src_ack), 0);
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/msg_fifo_arbiter.md
Name: msg_fifo_arbiter

Overview:
- Shares the single write port of the image processor's 32-bit CPU message FIFO between NUM_SRC independent message producers, such as per-colour bounding-box and distance reporters.
- Each producer posts a 3-word message: tag, word0, word1.
- The arbiter grants producers round-robin and writes each message atomically as 3 consecutive FIFO words. It starts a message only when the FIFO has room for all 3 words.
- Sits between the per-frame reporter logic and MSG_FIFO, which is read by the Avalon-MM slave.

Parameters:
- NUM_SRC, 5: number of producers (2..8).
- FIFO_DEPTH, 256: depth of the downstream message FIFO in words.
- USEDW_W, 8: width of the FIFO usedw input.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- src_req  in  NUM_SRC  per-source request, level; held until the matching src_ack
- src_tag  in  NUM_SRC*32  per-source header word; source i occupies [32i+31:32i]
- src_word0  in  NUM_SRC*32  per-source first payload word
- src_word1  in  NUM_SRC*32  per-source second payload word
- src_ack  out  NUM_SRC  one-cycle pulse on the winner's bit when its last word is written
- fifo_usedw  in  USEDW_W  FIFO occupancy
- fifo_flush  in  1  FIFO sclr/flush in progress
- fifo_wrreq  out  1  FIFO write strobe
- fifo_data  out  32  FIFO write data
- busy  out  1  high while a message is being written

Behaviour:
- Reset (async assert, sync release): state=IDLE; fifo_wrreq=0; fifo_data=0; src_ack=0; busy=0; rr_last=NUM_SRC-1, so source 0 has first priority.
- States: IDLE, HDR, W0, W1. Outputs are registered.
- IDLE: let space_ok = (fifo_usedw < FIFO_DEPTH-3) and !fifo_flush.
  - If |src_req and space_ok: pick the winner as the first set src_req bit searching upward from rr_last+1, wrapping modulo NUM_SRC.
  - Latch the winner index, its tag, word0 and word1 into snapshot registers.
  - Go to HDR.
  - Otherwise stay in IDLE.
- HDR: fifo_wrreq=1, fifo_data=tag snapshot; go to W0.
- W0: fifo_wrreq=1, fifo_data=word0 snapshot; go to W1.
- W1: fifo_wrreq=1, fifo_data=word1 snapshot, src_ack[winner]=1; rr_last<=winner; go to IDLE.
- busy=1 in HDR, W0 and W1.
- Timing: a request seen in IDLE at cycle k produces writes at k+1, k+2 and k+3, with the ack at k+3. The earliest next grant is at k+4. Peak rate is one message per 4 cycles.
- Snapshots are taken at grant. Source data may change after grant without corrupting the message in flight.
- A source must deassert src_req within 1 cycle of src_ack. A req still high at k+4 is treated as a new message.
- A src_req deassertion by a non-winner while another message is in flight has no effect.
- fifo_flush asserted in HDR, W0 or W1: go to IDLE on the next edge and write no further words. No src_ack is issued and rr_last is unchanged, so the same source re-wins and retries.
- Flush and src_ack in the same cycle (flush in W1): the word1 write and the ack still complete.
- FIFO nearly full (usedw >= FIFO_DEPTH-3): no grant is issued. Requests wait and are never dropped.
- fifo_wrreq is never asserted outside HDR, W0 and W1. fifo_data returns to 0 in IDLE.
- src_ack is one-hot or zero.
- An async reset mid-message aborts immediately, with no ack; the partial message stays in the FIFO, and the software flush clears it.

Optional Feature:
- MSG_ARB_SEQ_EN defined: an 8-bit sequence counter (reset 0) replaces tag[7:0] in the header word. The counter increments on every completed message (W1), wrapping 255->0. It does not increment on aborted messages.
- Not defined: tags pass through unmodified and the counter does not exist.

Decomposition:
- Package msg_arb_pkg holds:
  - the state enum (IDLE=2'd0, HDR=2'd1, W0=2'd2, W1=2'd3);
  - MSG_WORDS=3;
  - SEQ_W=8.
- Sub-module rr_arbiter (req vector plus last-grant in, one-hot grant and index out, purely combinational) is instantiated once.

Test Plan:
- Reset then src_req=5'b00001, tag=32'h00524242, w0=32'h1234_0056, w1=32'h0000_0101, usedw=0 -> wrreq high for 3 cycles with data 00524242, 12340056, 00000101; src_ack=00001 on the 3rd write cycle; busy for 3 cycles.
- src_req=5'b10101 held, re-asserted after each ack -> grant order 0, 2, 4, 0, 2, with exactly 4 cycles between successive headers.
- usedw=253 with src_req=00010 -> no wrreq; drop usedw to 252 -> message written with header one cycle after the drop is seen.
- fifo_flush pulsed during W0 of source 3 -> 2 words written (tag, word0), no src_ack, back to IDLE; with the flush gone, source 3 re-wins and the full 3-word message is written.
- Change src_word1 of the winner during HDR -> the FIFO receives the value latched at grant.
- MSG_ARB_SEQ_EN defined: 3 messages, then one aborted by a flush, then one more -> header low bytes 00, 01, 02, then 03 on the retry.
